// File: rtl/serdes_deframer.sv
// Serial-to-parallel receiver: bit-sliding sync-word hunt, fixed-length frame
// extraction and a valid/ready output FIFO with sticky overflow reporting.
module serdes_deframer #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(32'hA5A5_5A5A),
   parameter int unsigned      FRAME_WORDS = 4,
   parameter int unsigned      FIFO_DEPTH  = 4,
   parameter bit               LSB_FIRST   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             locked,
   output logic             sync_err,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam int unsigned FILL_W = $clog2(WIDTH + 1);
   localparam int unsigned BIT_W  = $clog2(WIDTH);
   localparam int unsigned WORD_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_HUNT, S_DATA, S_CHECK} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sr_q, sr_d, sr_shift;
   logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [WORD_W-1:0]  word_q, word_d;
   logic               sync_err_q, sync_err_d;
   logic               push;
   logic               fill_done, sync_hit, bit_last, word_last;

   logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               full, pop, push_ok, drop;

   // Shift register value after the current bit; all compares and pushes use it
   always_comb begin
      if (LSB_FIRST) sr_shift = {din, sr_q[WIDTH-1:1]};
      else           sr_shift = {sr_q[WIDTH-2:0], din};
      sr_d      = din_en ? sr_shift : sr_q;
      fill_inc  = (fill_q == FILL_W'(WIDTH)) ? fill_q : fill_q + FILL_W'(1);
      fill_d    = din_en ? fill_inc : fill_q;
      fill_done = (fill_inc == FILL_W'(WIDTH));
      sync_hit  = (sr_shift == SYNC_WORD);
      bit_last  = (bit_q == BIT_W'(WIDTH - 1));
      word_last = (word_q == WORD_W'(FRAME_WORDS - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_HUNT;
      else      state_q <= state_d;
   end

   // Next-state logic; nothing advances on din_en = 0 cycles
   always_comb begin
      state_d    = state_q;
      bit_d      = bit_q;
      word_d     = word_q;
      push       = 1'b0;
      sync_err_d = 1'b0;
      if (din_en) begin
         unique case (state_q)
            S_HUNT: begin
               if (fill_done && sync_hit) begin
                  state_d = S_DATA;
                  bit_d   = '0;
                  word_d  = '0;
               end
            end
            S_DATA: begin
               bit_d = bit_last ? '0 : bit_q + BIT_W'(1);
               if (bit_last) begin
                  push = 1'b1;
                  if (word_last) begin
                     state_d = S_CHECK;
                     word_d  = '0;
                  end else begin
                     word_d = word_q + WORD_W'(1);
                  end
               end
            end
            S_CHECK: begin
               bit_d = bit_last ? '0 : bit_q + BIT_W'(1);
               if (bit_last) begin
                  if (sync_hit) begin
                     state_d = S_DATA;
                     word_d  = '0;
                  end else begin
                     state_d    = S_HUNT;
                     sync_err_d = 1'b1;
                  end
               end
            end
            default: state_d = S_HUNT;
         endcase
      end
   end

   always_comb begin
      locked = (state_q != S_HUNT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q       <= '0;
         fill_q     <= '0;
         bit_q      <= '0;
         word_q     <= '0;
         sync_err_q <= 1'b0;
      end else begin
         sr_q       <= sr_d;
         fill_q     <= fill_d;
         bit_q      <= bit_d;
         word_q     <= word_d;
         sync_err_q <= sync_err_d;
      end
   end

   // Output FIFO: a push into a full FIFO survives only if a pop frees a slot
   always_comb begin
      full     = (cnt_q == CNT_W'(FIFO_DEPTH));
      pop      = dout_valid && dout_ready;
      push_ok  = push && (!full || pop);
      drop     = push && full && !pop;
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push_ok && pop) cnt_d = cnt_q - CNT_W'(1);
      ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= sr_shift;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   assign dout_valid = (cnt_q != '0);
   assign dout       = dout_valid ? mem_q[rd_ptr_q] : '0;
   assign sync_err   = sync_err_q;
   assign overflow   = ovf_q;

endmodule

// File: doc/serdes_deframer.md
# serdes_deframer

Parametrised serial-to-parallel receiver: shifts in a 1-bit stream, hunts for a programmable sync word, then emits fixed-length frames of WIDTH-bit data words through a valid/ready FIFO. It sits behind the serial pad logic in the SERDES receive path. It generalises the fixed 32-bit free-running deserializer with the following additions:
- configurable width and bit order
- frame alignment and loss-of-sync detection
- bit-enable gating
- output buffering with backpressure and overflow reporting

## Interface
Parameters:
- WIDTH, 32: word width in bits; must be ≥ 2.
- SYNC_WORD, 32'hA5A5_5A5A: WIDTH-bit frame header pattern.
- FRAME_WORDS, 4: data words per frame between sync words; must be ≥ 1.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of 2 and ≥ 2.
- LSB_FIRST, 1: 1 = first received bit lands in bit 0; 0 = first received bit lands in bit WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- din  in  1  serial data bit.
- din_en  in  1  din is sampled only when din_en = 1.
- dout  out  WIDTH  FIFO head word.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer accepts dout this cycle.
- locked  out  1  frame alignment held (state ≠ HUNT).
- sync_err  out  1  one-cycle pulse on sync-word mismatch.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of overflow.

## Operation
- Shift register sr (WIDTH bits) updates on each din_en cycle:
  - LSB_FIRST = 1: sr ← {din, sr[WIDTH-1:1]}.
  - LSB_FIRST = 0: sr ← {sr[WIDTH-2:0], din}.
  - All compares and pushes use sr_next, the value after the current bit.
- Fill counter saturates at WIDTH. It counts din_en bits since reset. A HUNT match is ignored until the fill counter reaches WIDTH after the current bit. This prevents a false lock when SYNC_WORD = 0.
- Bit counter bit_cnt runs 0..WIDTH-1 in DATA and CHECK. Word counter word_cnt runs 0..FRAME_WORDS-1.
- HUNT: on each din_en, if fill is complete and sr_next == SYNC_WORD, go to DATA with bit_cnt = 0 and word_cnt = 0.
- DATA: on the din_en where bit_cnt = WIDTH-1:
  - push sr_next to the FIFO;
  - if word_cnt = FRAME_WORDS-1, go to CHECK; otherwise increment word_cnt.
- CHECK: on the din_en where bit_cnt = WIDTH-1:
  - if sr_next == SYNC_WORD, go to DATA with word_cnt = 0;
  - otherwise go to HUNT and assert sync_err for that one cycle.
  - The sync word is never pushed.
- The HUNT compare is bit-sliding: alignment may start at any bit offset.
- FIFO:
  - dout = mem[rd_ptr], combinational read; dout_valid = (count ≠ 0).
  - Pop when dout_valid && dout_ready.
  - Push when full with no pop in the same cycle: the word is dropped and overflow is set.
  - Push when full with a simultaneous pop: both succeed and count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH+1) bits wide.
- overflow: set has priority over ovf_clr in the same cycle.
- The FIFO is not flushed on loss of sync; already-pushed words remain deliverable.

## Timing
- Reset (rst = 0) asynchronously forces:
  - state = HUNT; sr, fill, bit_cnt, word_cnt, FIFO pointers and count = 0;
  - dout_valid = 0, locked = 0, sync_err = 0, overflow = 0, dout = 0 (memory is not cleared, but dout is gated to 0 when empty).
- Reset mid-word or mid-frame discards partial data. Re-lock requires a full fill plus a sync word.
- Lock latency: locked goes high on the edge that samples the last sync bit.
- Word latency: the last data bit is sampled at edge k; dout_valid is visible after edge k if the FIFO was empty. There is no extra pipeline stage.
- A consumer with dout_ready held at 1 sees each word for exactly one cycle.
- Cycles with din_en = 0 freeze sr, every counter and the state.
- sync_err is registered, high for exactly the one cycle after the failing edge. locked falls on that same edge.

## Test plan
All scenarios use WIDTH = 8, SYNC_WORD = 8'hA5, FRAME_WORDS = 2, FIFO_DEPTH = 4, LSB_FIRST = 1, dout_ready = 1, unless stated otherwise.
- Basic frame: send A5, 3C, C3, A5 LSB-first, with din_en held high → locked rises after the 8th bit; dout = 3C then C3, one valid cycle each; the A5 headers never appear on dout; locked stays 1.
- Misalignment: send 3 junk bits (1, 1, 0), then the basic frame → lock occurs at the true A5 boundary; output is 3C, C3.
- din_en gaps: send the basic frame with din_en = 0 on every other cycle → identical output words; timing is stretched 2×.
- Sync loss: after A5, 11, 22, send 00 → sync_err is a single-cycle pulse; locked = 0; 11 and 22 are output; 00 is not output.
- Backpressure and overflow: hold dout_ready = 0 and send A5, 01, 02, A5, 03, 04, A5, 05, 06 →
  - FIFO holds 01–04; 05 and 06 are dropped; overflow = 1;
  - releasing dout_ready drains 01, 02, 03, 04 in order;
  - ovf_clr clears overflow.
- Full with simultaneous push/pop: with the FIFO full, push and pop in the same cycle → no drop, overflow stays 0.
- MSB-first and reset: with LSB_FIRST = 0, send bits 1,0,1,0,0,1,0,1 → lock. Then pull rst low in the middle of the next word → all outputs are 0 immediately; after release, locked stays 0 until a new full A5 is received.
